// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: data width, counter widths and ALU modes.
package cpu_pkg;

    localparam int DATA_WIDTH   = 8;  // register / bus / ALU operand width
    localparam int PC_WIDTH     = 8;  // default program-counter width
    localparam int UCYCLE_WIDTH = 4;  // width used by the microcycle counter

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    // Map the raw sub control bit onto the ALU mode enum.
    function automatic alu_op_e alu_mode(input logic sub_bit);
        return sub_bit ? ALU_SUB : ALU_ADD;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Parameterised N-bit load/increment counter. Load has priority over increment;
// both are qualified by en. Used for the program counter and the microcycle counter.
module pc_counter
    import cpu_pkg::*;
#(
    parameter int N = PC_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic         inc,
    input  logic [N-1:0] din,
    output logic [N-1:0] q
);

    logic [N-1:0] count_reg;
    logic [N-1:0] count_next;

    // Next-value selection: load beats increment, otherwise hold; wraps at all-ones.
    always_comb begin
        count_next = count_reg;
        if (en) begin
            if (load) begin
                count_next = din;
            end else if (inc) begin
                count_next = count_reg + {{(N-1){1'b0}}, 1'b1};
            end
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign q = count_reg;

endmodule

// File: rtl/exec_core.sv
// Execution-core primitives: glitch-free gated system clock, program counter,
// and add/subtract ALU with carry-out and zero flag on operand A.
module exec_core
    import cpu_pkg::*;
#(
    parameter int N = PC_WIDTH,
    parameter int W = DATA_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    output logic         clk_out,
    output logic         clk_inv,
    input  logic         pc_inc,
    input  logic         sel_in,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         cin,
    input  logic         sub,
    output logic [W-1:0] alu_out,
    output logic         cout,
    output logic         eq_zero
);

    // ------------------------------------------------------------------
    // Clock gate: enable is captured only while clk is low, so a change of
    // enable can never chop or create a partial high pulse on clk_out.
    // ------------------------------------------------------------------
    logic en_q;

    // Low-transparent enable latch, forced closed by reset.
    always_latch begin
        if (reset) begin
            en_q <= 1'b0;
        end else if (!clk) begin
            en_q <= enable;
        end
    end

    assign clk_out = clk & en_q;
    assign clk_inv = ~clk_out;

    // ------------------------------------------------------------------
    // Program counter: advances on clk edges that the gate lets through.
    // ------------------------------------------------------------------
    pc_counter #(
        .N (N)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (en_q),
        .load  (sel_in),
        .inc   (pc_inc),
        .din   (in),
        .q     (out)
    );

    // ------------------------------------------------------------------
    // ALU: subtract is A + ~B + 1, so carry-out doubles as "no borrow".
    // ------------------------------------------------------------------
    alu_op_e      alu_op;
    logic [W-1:0] b_eff;
    logic         c_eff;
    logic [W:0]   sum_ext;

    assign alu_op = alu_mode(sub);

    // Operand conditioning and W+1-bit sum; cin only matters when adding.
    always_comb begin
        b_eff   = in_b;
        c_eff   = cin;
        if (alu_op == ALU_SUB) begin
            b_eff = ~in_b;
            c_eff = 1'b1;
        end
        sum_ext = {1'b0, in_a} + {1'b0, b_eff} + {{W{1'b0}}, c_eff};
    end

    assign alu_out = sum_ext[W-1:0];
    assign cout    = sum_ext[W];
    assign eq_zero = (in_a == '0);

endmodule

// File: tb/tb_exec_core.sv
// Directed self-checking bench for exec_core with an arithmetic reference model.
module tb_exec_core;

    localparam int N = 8;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         clk_out;
    logic         clk_inv;
    logic         pc_inc;
    logic         sel_in;
    logic [N-1:0] din;
    logic [N-1:0] pc_q;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         cin;
    logic         sub;
    logic [W-1:0] alu_out;
    logic         cout;
    logic         eq_zero;

    int vectors    = 0;
    int miscompares = 0;
    bit check_on   = 1'b0;

    // reference model state
    int m_pc   = 0;
    bit m_gate = 1'b0;

    exec_core #(.N(N), .W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .clk_out (clk_out),
        .clk_inv (clk_inv),
        .pc_inc  (pc_inc),
        .sel_in  (sel_in),
        .in      (din),
        .out     (pc_q),
        .in_a    (in_a),
        .in_b    (in_b),
        .cin     (cin),
        .sub     (sub),
        .alu_out (alu_out),
        .cout    (cout),
        .eq_zero (eq_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic view of the ALU: add is plain sum, subtract is A-B with no-borrow flag.
    function automatic logic [W:0] alu_model(input int a, input int b, input int c, input bit s);
        int r;
        bit co;
        if (s) begin
            r  = (a - b + 256) % 256;
            co = (a >= b);
        end else begin
            r  = (a + b + c) % 256;
            co = ((a + b + c) >= 256);
        end
        return {co, r[W-1:0]};
    endfunction

    // Reset clears the model counter immediately.
    always @(posedge reset) m_pc = 0;

    // Model update on each rising edge, then compare mid-high-phase.
    always @(posedge clk) begin
        logic [W:0] exp_alu;
        if (reset) begin
            m_pc   = 0;
            m_gate = 1'b0;
        end else begin
            m_gate = enable;
            if (m_gate) begin
                if (sel_in)      m_pc = int'(din);
                else if (pc_inc) m_pc = (m_pc + 1) % 256;
            end
        end
        #2;
        if (check_on) begin
            exp_alu = alu_model(int'(in_a), int'(in_b), int'(cin), sub);
            check("pc", 32'(pc_q), 32'(m_pc));
            check("clk_out", 32'(clk_out), 32'(m_gate));
            check("clk_inv", 32'(clk_inv), 32'(!m_gate));
            check("alu_out", 32'(alu_out), 32'(exp_alu[W-1:0]));
            check("cout", 32'(cout), 32'(exp_alu[W]));
            check("eq_zero", 32'(eq_zero), 32'(in_a == 0));
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       s;
        logic [7:0] res;
        logic       co;
        logic       z;
    } alu_vec_t;

    alu_vec_t alu_tab[7] = '{
        '{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0},
        '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h05, 8'h03, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0},
        '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
        '{8'h07, 8'h07, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0},
        '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1},
        '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1}
    };

    task automatic drive(input bit en, input bit sel, input bit inc, input logic [7:0] d);
        @(negedge clk);
        #1;
        enable = en;
        sel_in = sel;
        pc_inc = inc;
        din    = d;
        in_a   = in_a + 8'd37;
        in_b   = in_b + 8'd91;
        sub    = ~sub;
        cin    = in_a[0];
    endtask

    initial begin
        logic [W:0] m;
        reset  = 1'b1;
        enable = 1'b1;
        pc_inc = 1'b0;
        sel_in = 1'b0;
        din    = '0;
        in_a   = '0;
        in_b   = '0;
        cin    = 1'b0;
        sub    = 1'b0;

        // reset state, sampled inside a high phase
        @(posedge clk);
        #2;
        check("rst_out", 32'(pc_q), 32'h00);
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_clk_inv", 32'(clk_inv), 32'h1);
        check("rst_eq_zero", 32'(eq_zero), 32'h1);

        // ALU literal vectors, each also cross-checked against the model
        for (int i = 0; i < 7; i++) begin
            in_a = alu_tab[i].a;
            in_b = alu_tab[i].b;
            cin  = alu_tab[i].c;
            sub  = alu_tab[i].s;
            #1;
            m = alu_model(int'(alu_tab[i].a), int'(alu_tab[i].b), int'(alu_tab[i].c), alu_tab[i].s);
            check("alu_lit_res", 32'(alu_out), 32'(alu_tab[i].res));
            check("alu_lit_cout", 32'(cout), 32'(alu_tab[i].co));
            check("alu_lit_zero", 32'(eq_zero), 32'(alu_tab[i].z));
            check("alu_model_pin", 32'(m), 32'({alu_tab[i].co, alu_tab[i].res}));
        end

        // release reset in a low phase and count three edges
        @(negedge clk);
        #1;
        reset    = 1'b0;
        pc_inc   = 1'b1;
        check_on = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("inc3", 32'(pc_q), 32'h03);

        // load 0xFE then increment through the wrap
        drive(1'b1, 1'b1, 1'b0, 8'hFE);
        @(posedge clk); #3;
        check("load_fe", 32'(pc_q), 32'hFE);
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        @(posedge clk); #3;
        check("inc_ff", 32'(pc_q), 32'hFF);
        @(posedge clk); #3;
        check("wrap_00", 32'(pc_q), 32'h00);

        // load has priority over increment
        drive(1'b1, 1'b1, 1'b1, 8'h2A);
        @(posedge clk); #3;
        check("load_prio", 32'(pc_q), 32'h2A);

        // gate closed: counter and clk_out frozen
        drive(1'b0, 1'b0, 1'b1, 8'h55);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #3;
            check("gated_out", 32'(pc_q), 32'h2A);
            check("gated_clk", 32'(clk_out), 32'h0);
        end

        // asynchronous reset in the middle of a high phase
        drive(1'b1, 1'b1, 1'b0, 8'h10);
        @(posedge clk); #3;
        check("pre_rst_out", 32'(pc_q), 32'h10);
        check("pre_rst_clk", 32'(clk_out), 32'h1);
        reset = 1'b1;
        #1;
        check("arst_out", 32'(pc_q), 32'h00);
        check("arst_clk_out", 32'(clk_out), 32'h0);
        check("arst_clk_inv", 32'(clk_inv), 32'h1);

        // release and resume counting from zero
        @(negedge clk);
        #1;
        reset  = 1'b0;
        sel_in = 1'b0;
        pc_inc = 1'b1;
        @(posedge clk); #3;
        check("resume_1", 32'(pc_q), 32'h01);
        @(posedge clk); #3;
        check("resume_2", 32'(pc_q), 32'h02);

        @(negedge clk);
        check_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
